// File: rtl/vga_pkg.sv
// Shared timing constants, display-mode encoding and pixel helpers for the VGA read path.
package vga_pkg;

  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;

  typedef enum logic [1:0] {
    MODE_COLOR  = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_MEDIAN = 2'd2,
    MODE_LATEST = 2'd3
  } disp_mode_t;

  // y*640 + x without a multiplier.
  function automatic logic [18:0] xy_to_addr(input logic [9:0] x, input logic [9:0] y);
    logic [18:0] yw;
    yw = {9'd0, y};
    return (yw << 9) + (yw << 7) + {9'd0, x};
  endfunction

  function automatic logic [3:0] expand3to4(input logic [2:0] v);
    return {v, v[2]};
  endfunction

  function automatic logic [2:0] median3(input logic [2:0] a, input logic [2:0] b,
                                         input logic [2:0] c);
    logic [2:0] lo, hi, mid;
    lo  = (a < b) ? a : b;
    hi  = (a < b) ? b : a;
    mid = (hi < c) ? hi : c;
    return (lo > mid) ? lo : mid;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with raw (unpipelined) sync, active-video and frame tick.
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int H_PERIOD  = H_TOTAL,
  parameter int V_PERIOD  = V_TOTAL,
  parameter int HS_BEGIN  = H_SYNC_START,
  parameter int HS_END    = H_SYNC_END,
  parameter int VS_BEGIN  = V_SYNC_START,
  parameter int VS_END    = V_SYNC_END
) (
  input  logic       clk_25m,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       vde_raw,
  output logic       frame_tick
);

  localparam logic [9:0] H_LAST = 10'(H_PERIOD - 1);
  localparam logic [9:0] V_LAST = 10'(V_PERIOD - 1);
  localparam logic [9:0] HS_LO  = 10'(HS_BEGIN);
  localparam logic [9:0] HS_HI  = 10'(HS_END);
  localparam logic [9:0] VS_LO  = 10'(VS_BEGIN);
  localparam logic [9:0] VS_HI  = 10'(VS_END);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign hsync_raw  = !((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
  assign vsync_raw  = !((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
  assign vde_raw    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_tick = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_frame_reader.sv
// VGA read side: raster timing, frame-buffer addressing and 9-bit word decode to RGB444.
// Counters -> address (stage 0), memory data (stage 1), registered pixel/sync (stage 2).
module vga_frame_reader import vga_pkg::*; #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BORDER   = 2
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic [1:0]  disp_mode,
  input  logic        compare_mode,
  input  logic [1:0]  frame_chunk_counter,
  output logic [18:0] bram_addr,
  input  logic [8:0]  bram_dout,
  output logic [9:0]  draw_x,
  output logic [9:0]  draw_y,
  output logic        vde,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [11:0] rgb
);

  localparam logic [9:0] X_LO    = 10'(BORDER);
  localparam logic [9:0] X_HI    = 10'(H_ACTIVE - BORDER);
  localparam logic [9:0] Y_LO    = 10'(BORDER);
  localparam logic [9:0] Y_HI    = 10'(V_ACTIVE - BORDER);
  localparam logic [9:0] X_SPLIT = 10'(H_ACTIVE / 2);

  logic [9:0] h_cnt, v_cnt;
  logic       hsync_raw, vsync_raw, vde_raw, frame_tick;

  vga_timing_gen #(
    .H_VISIBLE (H_ACTIVE),
    .V_VISIBLE (V_ACTIVE),
    .H_PERIOD  (H_ACTIVE + H_FP + H_SYNC + H_BP),
    .V_PERIOD  (V_ACTIVE + V_FP + V_SYNC + V_BP),
    .HS_BEGIN  (H_ACTIVE + H_FP),
    .HS_END    (H_ACTIVE + H_FP + H_SYNC - 1),
    .VS_BEGIN  (V_ACTIVE + V_FP),
    .VS_END    (V_ACTIVE + V_FP + V_SYNC - 1)
  ) u_timing (
    .clk_25m    (clk_25m),
    .rst_n      (rst_n),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .vde_raw    (vde_raw),
    .frame_tick (frame_tick)
  );

  assign bram_addr = vde_raw ? xy_to_addr(h_cnt, v_cnt) : '0;

  // Captured on the (0,0) edge so the whole frame, including pixel (0,0), sees one setting.
  disp_mode_t mode_q;
  logic       compare_q;
  logic [1:0] chunk_q;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_COLOR;
      compare_q <= 1'b0;
      chunk_q   <= 2'd0;
    end else if (frame_tick) begin
      mode_q    <= disp_mode_t'(disp_mode);
      compare_q <= compare_mode;
      chunk_q   <= (frame_chunk_counter == 2'd3) ? 2'd0 : frame_chunk_counter;
    end
  end

  logic [9:0] x1, y1;
  logic       vde1, hs1, vs1, fs1;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      x1   <= '0;
      y1   <= '0;
      vde1 <= 1'b0;
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      fs1  <= 1'b0;
    end else begin
      x1   <= h_cnt;
      y1   <= v_cnt;
      vde1 <= vde_raw;
      hs1  <= hsync_raw;
      vs1  <= vsync_raw;
      fs1  <= frame_tick;
    end
  end

  logic [2:0]  gray3;
  logic        use_gray;
  logic [11:0] pix;

  always_comb begin
    gray3    = bram_dout[8:6];
    use_gray = 1'b1;
    if (!(compare_q && (x1 >= X_SPLIT))) begin
      case (mode_q)
        MODE_COLOR:  use_gray = 1'b0;
        MODE_GRAY:   gray3 = bram_dout[8:6];
        MODE_MEDIAN: gray3 = median3(bram_dout[8:6], bram_dout[5:3], bram_dout[2:0]);
        MODE_LATEST: begin
          case (chunk_q)
            2'd1:    gray3 = bram_dout[5:3];
            2'd2:    gray3 = bram_dout[2:0];
            default: gray3 = bram_dout[8:6];
          endcase
        end
      endcase
    end
    if (use_gray) pix = {3{expand3to4(gray3)}};
    else pix = {expand3to4(bram_dout[8:6]), expand3to4(bram_dout[5:3]),
                expand3to4(bram_dout[2:0])};
    if (!vde1 || (x1 < X_LO) || (x1 >= X_HI) || (y1 < Y_LO) || (y1 >= Y_HI)) pix = '0;
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      draw_x      <= '0;
      draw_y      <= '0;
      vde         <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      rgb         <= '0;
    end else begin
      draw_x      <= x1;
      draw_y      <= y1;
      vde         <= vde1;
      hsync       <= hs1;
      vsync       <= vs1;
      frame_start <= fs1;
      rgb         <= pix;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader; vertical timing shortened (16 visible lines, 22 total)
// so several whole frames fit in a short run. Horizontal timing is the full 800-cycle line.
module tb_vga_frame_reader;

  logic        clk_25m = 1'b0;
  logic        rst_n;
  logic [1:0]  disp_mode;
  logic        compare_mode;
  logic [1:0]  frame_chunk_counter;
  logic [18:0] bram_addr;
  logic [8:0]  bram_dout;
  logic [9:0]  draw_x, draw_y;
  logic        vde, hsync, vsync, frame_start;
  logic [11:0] rgb;

  logic [8:0]  mem_word = 9'd0;
  logic [8:0]  hot_word = 9'd0;
  logic [18:0] hot_addr = 19'h7FFFF;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  vga_frame_reader #(
    .V_ACTIVE (16),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2)
  ) dut (
    .clk_25m             (clk_25m),
    .rst_n               (rst_n),
    .disp_mode           (disp_mode),
    .compare_mode        (compare_mode),
    .frame_chunk_counter (frame_chunk_counter),
    .bram_addr           (bram_addr),
    .bram_dout           (bram_dout),
    .draw_x              (draw_x),
    .draw_y              (draw_y),
    .vde                 (vde),
    .hsync               (hsync),
    .vsync               (vsync),
    .frame_start         (frame_start),
    .rgb                 (rgb)
  );

  always #20 clk_25m = ~clk_25m;

  // One-cycle read latency memory; a single "hot" address can return a distinct word.
  always @(posedge clk_25m) begin
    bram_dout <= (bram_addr == hot_addr) ? hot_word : mem_word;
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pixel(input string tag, input int x, input int y);
    int n;
    n = 0;
    while (!(draw_x == 10'(x) && draw_y == 10'(y)) && n < 20000) begin
      @(negedge clk_25m);
      n++;
    end
    check({tag, "_reached"}, (draw_x == 10'(x) && draw_y == 10'(y)), 1);
  endtask

  task automatic restart(input logic [1:0] mode, input logic cmp, input logic [1:0] chunk);
    disp_mode           = mode;
    compare_mode        = cmp;
    frame_chunk_counter = chunk;
    @(negedge clk_25m);
    rst_n = 1'b0;
    @(negedge clk_25m);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, rel, fs_at, t_fall;
    rst_n = 1'b0;
    disp_mode = 2'd0;
    compare_mode = 1'b0;
    frame_chunk_counter = 2'd0;
    repeat (3) @(negedge clk_25m);

    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_vde", vde, 0);
    check("rst_rgb", rgb, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_draw_xy", {draw_x, draw_y}, 0);
    check("rst_addr", bram_addr, 0);

    // Raster timing from release
    rst_n = 1'b1;
    rel = cyc;
    fs_at = -1;
    n = 0;
    while (hsync && n < 2000) begin
      @(negedge clk_25m);
      n++;
      if (frame_start && fs_at < 0) fs_at = cyc - rel;
    end
    check("hsync_first_fall", cyc - rel, 658);
    check("frame_start_first", fs_at, 2);
    t_fall = cyc;
    n = 0;
    while (!hsync && n < 2000) begin @(negedge clk_25m); n++; end
    check("hsync_width", cyc - t_fall, 96);
    while (hsync && n < 4000) begin @(negedge clk_25m); n++; end
    check("line_period", cyc - t_fall, 800);

    n = 0;
    while (vsync && n < 30000) begin @(negedge clk_25m); n++; end
    check("vsync_fall", cyc - rel, 18 * 800 + 2);
    t_fall = cyc;
    while (!vsync && n < 30000) begin @(negedge clk_25m); n++; end
    check("vsync_width", cyc - t_fall, 1600);
    while (!frame_start && n < 30000) begin @(negedge clk_25m); n++; end
    check("frame_period", cyc - rel - 2, 22 * 800);

    // COLOR: address and two-cycle alignment of one hot pixel at (100,5)
    mem_word = 9'd0;
    hot_word = 9'b111_100_001;
    hot_addr = 19'd3300;
    restart(2'd0, 1'b0, 2'd0);
    wait_pixel("color_x98", 98, 5);
    check("addr_100_5", bram_addr, 3300);
    wait_pixel("color_x99", 99, 5);
    check("color_before_hot", rgb, 12'h000);
    wait_pixel("color_x100", 100, 5);
    check("color_hot", rgb, 12'hF92);
    check("color_vde", vde, 1);
    wait_pixel("color_x101", 101, 5);
    check("color_after_hot", rgb, 12'h000);
    wait_pixel("hblank", 700, 5);
    check("hblank_rgb", rgb, 12'h000);
    check("hblank_vde", vde, 0);
    check("hblank_addr", bram_addr, 0);
    hot_addr = 19'h7FFFF;

    mem_word = 9'b101_010_011;
    restart(2'd1, 1'b0, 2'd0);
    wait_pixel("gray", 5, 3);
    check("gray_101", rgb, 12'hBBB);

    mem_word = 9'b001_110_100;
    restart(2'd2, 1'b0, 2'd0);
    wait_pixel("med_a", 6, 2);
    check("median_1_6_4", rgb, 12'h999);
    mem_word = 9'b101_101_010;
    wait_pixel("med_b", 10, 3);
    check("median_5_5_2", rgb, 12'hBBB);
    mem_word = 9'b110_001_011;
    wait_pixel("med_c", 10, 4);
    check("median_6_1_3", rgb, 12'h666);

    // LATEST: chunk held for the frame, new value picked up at the next frame start
    mem_word = 9'b001_110_100;
    restart(2'd3, 1'b0, 2'd1);
    wait_pixel("latest_a", 20, 2);
    check("latest_chunk1", rgb, 12'hDDD);
    frame_chunk_counter = 2'd2;
    wait_pixel("latest_b", 20, 3);
    check("latest_held", rgb, 12'hDDD);
    n = 0;
    while (!frame_start && n < 20000) begin @(negedge clk_25m); n++; end
    check("latest_next_frame", frame_start, 1);
    wait_pixel("latest_c", 20, 2);
    check("latest_chunk2", rgb, 12'h999);
    restart(2'd3, 1'b0, 2'd3);
    wait_pixel("latest_d", 20, 2);
    check("latest_chunk3_as_0", rgb, 12'h222);

    // Compare split at x=320
    mem_word = 9'b010_111_000;
    restart(2'd0, 1'b1, 2'd0);
    wait_pixel("cmp_a", 319, 2);
    check("cmp_x319_color", rgb, 12'h4F0);
    wait_pixel("cmp_b", 320, 2);
    check("cmp_x320_gray", rgb, 12'h444);
    compare_mode = 1'b0;
    wait_pixel("cmp_c", 320, 3);
    check("cmp_held", rgb, 12'h444);

    // Border blanking
    mem_word = 9'b111_111_111;
    restart(2'd0, 1'b0, 2'd0);
    wait_pixel("b_y0", 2, 0);
    check("border_y0", rgb, 12'h000);
    wait_pixel("b_y1", 2, 1);
    check("border_y1", rgb, 12'h000);
    wait_pixel("b_x0", 0, 2);
    check("border_x0", rgb, 12'h000);
    wait_pixel("b_x1", 1, 2);
    check("border_x1", rgb, 12'h000);
    wait_pixel("b_in", 2, 2);
    check("border_x2y2_pass", rgb, 12'hFFF);
    wait_pixel("b_x637", 637, 2);
    check("border_x637_pass", rgb, 12'hFFF);
    wait_pixel("b_x638", 638, 2);
    check("border_x638", rgb, 12'h000);
    wait_pixel("b_x639", 639, 2);
    check("border_x639", rgb, 12'h000);
    wait_pixel("b_y13", 100, 13);
    check("border_y13_pass", rgb, 12'hFFF);
    wait_pixel("b_y14", 100, 14);
    check("border_y14", rgb, 12'h000);
    wait_pixel("b_y15", 100, 15);
    check("border_y15", rgb, 12'h000);
    wait_pixel("vblank", 98, 16);
    check("vblank_addr", bram_addr, 0);
    check("vblank_vde", vde, 0);
    @(negedge clk_25m);
    @(negedge clk_25m);
    check("vblank_rgb", rgb, 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
Read-side companion to the frame buffer. It generates 640x480@60 VGA timing on clk_25m and drives frame-buffer port B addresses. It decodes the returned 9-bit words (RGB333, single 3-bit gray, or 3-frame packed temporal history) into 12-bit RGB444 for the VGA encoder. It applies a per-frame latched display mode, a compare split and border blanking.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
BORDER, 2, blanked rows/columns at each edge

Ports:
clk_25m  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
disp_mode  in  2  0 COLOR, 1 GRAY, 2 TEMPORAL_MEDIAN, 3 TEMPORAL_LATEST
compare_mode  in  1  right half (x>=320) forced to GRAY decode
frame_chunk_counter  in  2  chunk index of last completed camera frame (0..2)
bram_addr  out  19  port B read address, y*640+x
bram_dout  in  9  port B data, valid 1 cycle after bram_addr
draw_x  out  10  pixel x aligned to rgb
draw_y  out  10  pixel y aligned to rgb
vde  out  1  active video, aligned to rgb
hsync  out  1  active-low, aligned to rgb
vsync  out  1  active-low, aligned to rgb
frame_start  out  1  1-cycle pulse when counters wrap to (0,0)
rgb  out  12  RGB444 pixel

Behaviour:
- Reset: h_cnt=0, v_cnt=0; hsync=1, vsync=1, vde=0, rgb=0, draw_x=0, draw_y=0, frame_start=0, latched mode=COLOR, latched chunk=0.
- Counters: h_cnt wraps 799->0. v_cnt increments on the h wrap and wraps 524->0.
- Sync timing: hsync low for h_cnt in [656,751]. vsync low for v_cnt in [490,491]. Active when h<640 and v<480.
- Stage 0: bram_addr is combinational from the registered counters, computed as (y<<9)+(y<<7)+x. It is 0 outside the active area.
- Stage 1: bram_dout returns. Counters and sync are carried in a 1-deep pipe.
- Stage 2: decoded rgb and the delayed sync/vde/draw_x/draw_y are registered together. Total latency from counter to pins is 2 cycles, with all outputs aligned.
- Mode latch: disp_mode, compare_mode and frame_chunk_counter are sampled only when the counters are at (0,0). They are held for the whole frame, so mid-frame input changes have no effect until the next frame. frame_chunk_counter=3 is treated as 0.
- Expansion rule: 3-bit v becomes 4-bit {v, v[2]}. Gray g becomes rgb={e,e,e}, where e is the expanded g.
- COLOR: r=[8:6], g=[5:3], b=[2:0], each expanded.
- GRAY: gray from [8:6].
- TEMPORAL_MEDIAN: median of chunks a=[8:6], b=[5:3], c=[2:0], computed as max(min(a,b), min(max(a,b),c)). Equal values are allowed; the result is always one of the three.
- TEMPORAL_LATEST: gray from the chunk selected by the latched counter (0->[8:6], 1->[5:3], 2->[2:0]).
- Compare: when latched compare=1 and x>=320, GRAY decode is used regardless of mode.
- Blanking: rgb=0 when vde=0, or x<BORDER, or x>=H_ACTIVE-BORDER, or y<BORDER, or y>=V_ACTIVE-BORDER.
- frame_start: asserted with stage-2 alignment for the (0,0) pixel, once per 420000 cycles.
- Reset mid-frame: all state clears immediately and the frame restarts at (0,0) after release. No partial-line outputs.

Decomposition:
- Package vga_pkg:
  - timing localparams (H_TOTAL=800, V_TOTAL=525, sync start/end);
  - disp_mode_t enum;
  - functions xy_to_addr, expand3to4, median3.
- One sub-module vga_timing_gen holds the counters, raw sync/vde and the frame_start tick. The reader instantiates it and adds the decode pipeline.

Test Plan:
1. Reset release -> hsync=1, vsync=1, vde=0, rgb=0. The first hsync falling edge occurs 658 cycles after release (656 plus 2 pipe). hsync stays low 96 cycles. Line period is 800 cycles, frame period 420000.
2. COLOR at (100,50): check bram_addr=32100. Model returns 9'b111_100_001 -> rgb=0xF92 two cycles after the address.
3. GRAY with data [8:6]=3'b101 -> rgb=0xBBB. TEMPORAL_MEDIAN with chunks (1,6,4) -> 0x999. TEMPORAL_MEDIAN with (5,5,2) -> 0xBBB.
4. TEMPORAL_LATEST: chunk counter=1 latched at frame start, data {1,6,4} -> 0xDDD. Changing the counter to 2 mid-frame keeps 0xDDD until the next frame_start, then 0x999.
5. Compare on, COLOR, data 9'b010_111_000: x=319 -> 0x4F0, x=320 -> 0x444.
6. Borders: nonzero data at x=0,1,638,639 and y=0,1,478,479 -> rgb=0. Data at x=2,y=2 passes. Blanking-interval rgb=0 and bram_addr=0.
